// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port RAM between the VGA fetch path
// (fixed priority), a draw-engine writer (req/ack) and a clear-screen engine.
// Net HCount -> RGB latency is 2 clocks; the top level delays the syncs to match.
module vga_fb_arbiter #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned FB_W     = 160,
   parameter int unsigned FB_H     = 120,
   parameter int unsigned ADDR_W   = 15,
   parameter int unsigned FB_DEPTH = FB_W * FB_H
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        HCount,
   input  logic [9:0]        VCount,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [2:0]        wr_data,
   output logic              wr_ack,
   input  logic              clear_req,
   input  logic [2:0]        clear_color,
   output logic              clear_busy,
   output logic              frame_tick,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [2:0]        ram_wdata,
   input  logic [2:0]        ram_rdata,
   output logic [2:0]        RGB
);

   typedef enum logic [1:0] {IDLE, ARM, CLEAR} state_t;

   state_t            state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [2:0]        clr_color;
   logic [2:0]        pix;
   logic [1:0]        active_d;
   logic              slot_d;

   logic              active_c;
   logic              slot_c;
   logic              vblank_start_c;
   logic              wr_in_range_c;
   logic [ADDR_W-1:0] row_c;
   logic [ADDR_W-1:0] disp_addr_c;

   // Region decode and display address: (VCount>>2)*160 as (v<<7)+(v<<5)
   assign active_c       = (HCount < 10'(H_ACTIVE)) && (VCount < 10'(V_ACTIVE));
   assign slot_c         = active_c && (HCount[1:0] == 2'b00);
   assign vblank_start_c = (VCount == 10'(V_ACTIVE)) && (HCount == 10'd0);
   assign wr_in_range_c  = wr_addr < ADDR_W'(FB_DEPTH);
   assign row_c          = ADDR_W'(VCount[9:2]);
   assign disp_addr_c    = (row_c << 7) + (row_c << 5) + ADDR_W'(HCount[9:2]);

   // RAM port mux: display slot wins, free slots go to the FSM owner
   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      wr_ack    = 1'b0;
      if (!rst) begin
         if (slot_c) begin
            ram_addr = disp_addr_c;
         end else begin
            case (state)
               IDLE: begin
                  if (wr_req) begin
                     wr_ack = 1'b1;
                     if (wr_in_range_c) begin
                        ram_we    = 1'b1;
                        ram_addr  = wr_addr;
                        ram_wdata = wr_data;
                     end
                  end
               end
               CLEAR: begin
                  ram_we    = 1'b1;
                  ram_addr  = clr_cnt;
                  ram_wdata = clr_color;
               end
               default: ;
            endcase
         end
      end
   end

   // Frame tick marks the first cycle of vertical blank regardless of FSM state
   assign frame_tick = !rst && vblank_start_c;

   // Pixel output gated by the active flag delayed to match the read pipeline
   assign RGB = (!rst && active_d[1]) ? pix : 3'b000;

   // Display pipeline and clear-engine FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         clear_busy <= 1'b0;
         clr_cnt    <= '0;
         clr_color  <= '0;
         pix        <= '0;
         active_d   <= '0;
         slot_d     <= 1'b0;
      end else begin
         active_d <= {active_d[0], active_c};
         slot_d   <= slot_c;
         if (slot_d) begin
            pix <= ram_rdata;
         end
         case (state)
            IDLE: begin
               if (clear_req) begin
                  clr_color  <= clear_color;
                  clear_busy <= 1'b1;
                  state      <= ARM;
               end
            end
            ARM: begin
               if (vblank_start_c) begin
                  clr_cnt <= '0;
                  state   <= CLEAR;
               end
            end
            CLEAR: begin
               if (!slot_c) begin
                  if (clr_cnt == ADDR_W'(FB_DEPTH - 1)) begin
                     clear_busy <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     clr_cnt <= clr_cnt + ADDR_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM between three users:
  - the VGA display fetch path, which has fixed priority;
  - a draw-engine write requester, using a req/ack handshake;
  - an internal clear-screen engine.
- Sits between VGA_Controller (supplies HCount/VCount) and the frame-buffer RAM. It replaces the combinational DrawSystem colour source with a 160x120, 3-bit-per-pixel buffer upscaled 4x to 640x480.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- FB_W, 160, buffer width (H_ACTIVE/4).
- FB_H, 120, buffer height (V_ACTIVE/4).
- ADDR_W, 15, RAM address width.
- FB_DEPTH, 19200, valid RAM words (FB_W*FB_H).

Ports:
- clk  in  1  pixel clock; same clock as VGA_Controller.
- rst  in  1  synchronous, active-high reset.
- HCount  in  10  current horizontal count from VGA_Controller.
- VCount  in  10  current vertical count from VGA_Controller.
- wr_req  in  1  draw-engine write request; held high until wr_ack.
- wr_addr  in  ADDR_W  write address, computed as y*160+x.
- wr_data  in  3  write colour.
- wr_ack  out  1  one-cycle pulse: the request is retired this cycle.
- clear_req  in  1  one-cycle pulse requesting a full-buffer clear.
- clear_color  in  3  fill colour, sampled when clear_req is accepted.
- clear_busy  out  1  high from clear acceptance until the clear completes.
- frame_tick  out  1  one-cycle pulse at the start of vertical blank.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  3  RAM write data.
- ram_rdata  in  3  RAM read data, valid one cycle after the address is presented.
- RGB  out  3  pixel colour to the DAC pins.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset values: wr_ack=0, clear_busy=0, frame_tick=0, RGB=0, ram_we=0, ram_addr=0, ram_wdata=0, pixel register=0, FSM=IDLE.
  - ram_we must be 0 in every cycle where rst=1.
- Active region: active = (HCount<H_ACTIVE) && (VCount<V_ACTIVE).
- Display slot: active && HCount[1:0]==0.
  - ram_addr = (VCount>>2)*FB_W + (HCount>>2), ram_we=0.
  - The display slot always wins; no other user may drive the RAM in that cycle.
- Display pipeline:
  - Read issued in cycle t; ram_rdata captured into the pixel register at the end of t+1.
  - RGB = pixel register when active delayed by 2 cycles, else 0.
  - Net latency HCount -> RGB is 2 cycles. The top level delays HSync/VSync by 2 registers to match.
  - Each buffer pixel is shown for 4 clocks and 4 lines.
- Non-display cycles are free slots. Their use is decided by the FSM.
- FSM IDLE:
  - On a free slot with wr_req=1: ram_we=1 if wr_addr<FB_DEPTH, with ram_addr=wr_addr and ram_wdata=wr_data; wr_ack=1 in the same cycle.
  - If wr_addr>=FB_DEPTH: wr_ack=1 but ram_we=0, so the write is dropped and the requester is not blocked.
  - At most one write per free slot. wr_ack is 0 on display slots.
  - clear_req=1 -> latch clear_color, set clear_busy=1, go to ARM.
    - If clear_req and a write coincide, the write in that cycle still completes.
- FSM ARM:
  - Writer stalled (wr_ack=0).
  - When VCount==V_ACTIVE && HCount==0: clear counter=0, go to CLEAR.
- FSM CLEAR:
  - Every cycle: ram_we=1, ram_addr=counter, ram_wdata=latched colour; counter+1.
  - There are no display slots during vertical blank.
  - After the write to FB_DEPTH-1, the next cycle is IDLE with clear_busy=0.
  - The clear takes 19200 cycles, which fits inside the 45-line vertical blank (36000 cycles at 800 clocks/line).
- clear_req while clear_busy=1: ignored. No re-arm and no colour change.
- frame_tick: 1 exactly in the cycle where VCount==V_ACTIVE && HCount==0, independent of FSM state.
- Reset mid-clear: FSM returns to IDLE and clear_busy=0. Words already written stay written; the rest are untouched.
- Arithmetic:
  - (VCount>>2)*160 is computed as (v<<7)+(v<<5) with no multiplier.
  - The result is truncated to ADDR_W. The maximum is 19199, so there is no overflow.

Test Plan:
- Reset held 3 cycles with wr_req=1 -> ram_we=0, wr_ack=0, RGB=0 throughout; all outputs at reset values one cycle after rst falls.
- Preload word 0=3'b101 and word 161=3'b010; run a frame -> RGB=101 at HCount 2..5 of lines 0..3 (2-cycle lag); RGB=010 at the 4 clocks lagging HCount 4..7 by 2 on lines 4..7; RGB=0 whenever HCount>=640 (delayed).
- Hold wr_req with wr_addr=5 and wr_data=3'b110 starting at HCount=0, VCount=10 -> no ack at HCount 0; wr_ack and ram_we=1 at HCount=1; RAM word 5=110.
- wr_req with wr_addr=19200 during horizontal blank -> wr_ack=1 the same cycle, ram_we=0, RAM unchanged.
- clear_req with clear_color=3'b011 at VCount=100 -> clear_busy=1, writer unacked until VCount=480, HCount=0; then 19200 consecutive ram_we=1 cycles on addresses 0..19199; clear_busy falls after the last one; the next frame shows RGB=011 everywhere.
- Assert rst after 1000 clear writes -> FSM idle, clear_busy=0, words 0..999 equal clear_color, word 1000 unchanged; a second clear_req while busy in a separate run -> colour unchanged and a single sweep.
